// File: rtl/alu_divider.sv
// alu_divider: sequential restoring divider, 32-bit dividend / 16-bit divisor.
// Produces one quotient bit per clock over 16 iterations. B==0 and quotients
// that cannot fit 16 bits are flagged immediately, without running the core.
// Optional feature macro: ALU_DIV_SIGNED_EN (two's complement operands when sgn=1).
module alu_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sgn,
  input  logic [31:0] A,
  input  logic [15:0] B,
  output logic [15:0] Q,
  output logic [15:0] R,
  output logic        busy,
  output logic        done,
  output logic        dz,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] rem;
  logic [15:0] dvd;
  logic [15:0] dsr;
  logic [31:0] mag_a;
  logic [15:0] mag_b;
  logic        accept;
  logic        err_dz;
  logic        err_ovf;
  logic [16:0] trial;
  logic        qbit;
  logic [15:0] rem_nx;
  logic [15:0] dvd_nx;
  logic [32:0] fin;

`ifdef ALU_DIV_SIGNED_EN
  logic [15:0] a_lo;
  logic        sgn_op;
  logic        neg_q;
  logic        neg_r;

  function automatic logic [31:0] mag32(input logic signed [31:0] v);
    return v[31] ? -v : v;
  endfunction

  function automatic logic [15:0] mag16(input logic signed [15:0] v);
    return v[15] ? -v : v;
  endfunction

  // Apply signs to the unsigned core result; out-of-range signed quotients
  // saturate to the same error pattern as the early overflow path.
  function automatic logic [32:0] sign_fix(input logic sop, input logic nq, input logic nr,
                                           input logic [15:0] q_mag, input logic [15:0] r_mag,
                                           input logic [15:0] alo);
    logic               o;
    logic signed [15:0] q_s;
    logic signed [15:0] r_s;
    o   = sop && (nq ? (q_mag > 16'd32768) : (q_mag > 16'd32767));
    q_s = nq ? -$signed(q_mag) : $signed(q_mag);
    r_s = nr ? -$signed(r_mag) : $signed(r_mag);
    if (o) return {1'b1, 16'hFFFF, alo};
    return {1'b0, q_s, r_s};
  endfunction

  assign mag_a = sgn ? mag32(A) : A;
  assign mag_b = sgn ? mag16(B) : B;
  assign fin   = sign_fix(sgn_op, neg_q, neg_r, dvd_nx, rem_nx, a_lo);
`else
  logic sgn_unused;

  assign sgn_unused = sgn;
  assign mag_a      = A;
  assign mag_b      = B;
  assign fin        = {1'b0, dvd_nx, rem_nx};
`endif

  assign accept  = (state == IDLE) && start;
  assign err_dz  = (mag_b == 16'd0);
  assign err_ovf = !err_dz && (mag_a[31:16] >= mag_b);

  // One restoring step: 17-bit trial subtract, bit 16 set means negative.
  assign trial  = {rem, dvd[15]} - {1'b0, dsr};
  assign qbit   = ~trial[16];
  assign rem_nx = qbit ? trial[15:0] : {rem[14:0], dvd[15]};
  assign dvd_nx = {dvd[14:0], qbit};

  // Datapath: load magnitudes on accept, iterate while running.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem <= mag_a[31:16];
      dvd <= mag_a[15:0];
      dsr <= mag_b;
`ifdef ALU_DIV_SIGNED_EN
      a_lo   <= A[15:0];
      sgn_op <= sgn;
      neg_q  <= sgn & (A[31] ^ B[15]);
      neg_r  <= sgn & A[31];
`endif
    end else if (state == RUN) begin
      rem <= rem_nx;
      dvd <= dvd_nx;
    end
  end

  // Control FSM with registered results and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 4'd0;
      Q     <= 16'h0000;
      R     <= 16'h0000;
      busy  <= 1'b0;
      done  <= 1'b0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            cnt <= 4'd0;
            if (err_dz || err_ovf) begin
              dz    <= err_dz;
              ovf   <= err_ovf;
              Q     <= 16'hFFFF;
              R     <= A[15:0];
              done  <= 1'b1;
              state <= DONE;
            end else begin
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) begin
            ovf   <= fin[32];
            dz    <= 1'b0;
            Q     <= fin[31:16];
            R     <= fin[15:0];
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Directed self-checking bench for alu_divider.
module tb_alu_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] A;
  logic [15:0] B;
  logic [15:0] Q;
  logic [15:0] R;
  logic        busy;
  logic        done;
  logic        dz;
  logic        ovf;

  int   errors = 0;
  int   checks = 0;
  int   lat;
  logic saw_done;

  alu_divider dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .A(A), .B(B),
    .Q(Q), .R(R), .busy(busy), .done(done), .dz(dz), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one request; returns just after the accepting edge (latency 1).
  task automatic go(input logic s, input logic [31:0] a, input logic [15:0] b);
    sgn   = s;
    A     = a;
    B     = b;
    start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int l);
    l = lat0;
    while (done !== 1'b1 && l < 40) begin
      tick;
      l++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; A = 32'd0; B = 16'd0;
    tick;
    tick;
    rst = 1'b0;
    chk("rst_q", {16'd0, Q}, 32'h0);
    chk("rst_r", {16'd0, R}, 32'h0);
    chk("rst_flags", {28'd0, busy, done, dz, ovf}, 32'h0);

    // 100 / 7
    go(1'b0, 32'd100, 16'd7);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(1, lat);
    chk("t1_lat", lat, 32'd17);
    chk("t1_q", {16'd0, Q}, 32'd14);
    chk("t1_r", {16'd0, R}, 32'd2);
    chk("t1_flags", {29'd0, busy, dz, ovf}, 32'h0);
    tick;
    chk("t1_done_pulse", {31'd0, done}, 32'd0);
    tick;
    chk("t1_hold_q", {16'd0, Q}, 32'd14);

    // Largest in-range quotient
    go(1'b0, 32'hFFFE_0001, 16'hFFFF);
    wait_done(1, lat);
    chk("t2a_lat", lat, 32'd17);
    chk("t2a_q", {16'd0, Q}, 32'h0000FFFF);
    chk("t2a_r", {16'd0, R}, 32'h0);
    chk("t2a_ovf", {31'd0, ovf}, 32'd0);
    tick;

    // Quotient overflow detected at accept
    go(1'b0, 32'h0001_0000, 16'd1);
    wait_done(1, lat);
    chk("t2b_lat", lat, 32'd1);
    chk("t2b_ovf_dz", {30'd0, ovf, dz}, 32'b10);
    chk("t2b_qr", {Q, R}, 32'hFFFF_0000);
    tick;

    // Divide by zero
    go(1'b0, 32'h0000_1234, 16'd0);
    wait_done(1, lat);
    chk("t3_lat", lat, 32'd1);
    chk("t3_ovf_dz", {30'd0, ovf, dz}, 32'b01);
    chk("t3_qr", {Q, R}, 32'hFFFF_1234);
    tick;

    // Start re-pulsed during RUN is ignored
    go(1'b0, 32'd100, 16'd7);
    repeat (4) tick;
    A = 32'd9; B = 16'd3; start = 1'b1;
    tick;
    start = 1'b0;
    wait_done(6, lat);
    chk("t4_lat", lat, 32'd17);
    chk("t4_qr", {Q, R}, {16'd14, 16'd2});
    chk("t4_dz_after_dz", {31'd0, dz}, 32'd0);
    tick;

    // Reset mid-run aborts with no done pulse
    go(1'b0, 32'd100, 16'd7);
    repeat (7) tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("t5_busy", {31'd0, busy}, 32'd0);
    chk("t5_qr", {Q, R}, 32'h0);
    saw_done = done;
    repeat (20) begin
      tick;
      if (done === 1'b1) saw_done = 1'b1;
    end
    chk("t5_no_done", {31'd0, saw_done}, 32'd0);
    go(1'b0, 32'd1000, 16'd33);
    wait_done(1, lat);
    chk("t5_lat", lat, 32'd17);
    chk("t5_qr_after", {Q, R}, {16'd30, 16'd10});
    tick;

    // -100 / 7 with sgn=1
    go(1'b1, 32'hFFFF_FF9C, 16'd7);
    wait_done(1, lat);
`ifdef ALU_DIV_SIGNED_EN
    chk("t6_lat", lat, 32'd17);
    chk("t6_qr", {Q, R}, 32'hFFF2_FFFE);
    chk("t6_ovf", {31'd0, ovf}, 32'd0);
`else
    chk("t6_lat", lat, 32'd1);
    chk("t6_qr", {Q, R}, 32'hFFFF_FF9C);
    chk("t6_ovf", {31'd0, ovf}, 32'd1);
`endif
    tick;

    // 32768 / 1 with sgn=1: out of signed range, fine unsigned
    go(1'b1, 32'h0000_8000, 16'd1);
    wait_done(1, lat);
    chk("t7_lat", lat, 32'd17);
`ifdef ALU_DIV_SIGNED_EN
    chk("t7_qr", {Q, R}, 32'hFFFF_8000);
    chk("t7_ovf", {31'd0, ovf}, 32'd1);
`else
    chk("t7_qr", {Q, R}, 32'h8000_0000);
    chk("t7_ovf", {31'd0, ovf}, 32'd0);
`endif
    tick;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
